// File: rtl/debounce_edge_det.sv
// Debouncer for an asynchronous, possibly bouncing level input: a synchronizer chain feeds
// a four-state qualifier that produces a registered level, edge pulses and a rise counter.
module debounce_edge_det #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       d_i,
    output logic       q_o,
    output logic       qb_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic       busy_o,
    output logic [7:0] rise_cnt_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain_p0;
    logic                   sync;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic                   level_nxt;
    logic                   busy_nxt;

    // Stage 0: synchronizer; only the final flop is safe to observe
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_chain_p0 <= '0;
        end else begin
            sync_chain_p0 <= {sync_chain_p0[SYNC_STAGES-2:0], d_i};
        end
    end

    assign sync = sync_chain_p0[SYNC_STAGES-1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            STABLE_LO: begin
                if (sync) begin
                    state_nxt = CHECK_HI;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CHECK_HI: begin
                if (!sync) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!sync) begin
                    state_nxt = CHECK_LO;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CHECK_LO: begin
                if (sync) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it
    assign rise_nxt  = (state == CHECK_HI) && (state_nxt == STABLE_HI);
    assign fall_nxt  = (state == CHECK_LO) && (state_nxt == STABLE_LO);
    assign level_nxt = (state_nxt == STABLE_HI) || (state_nxt == CHECK_LO);
    assign busy_nxt  = (state_nxt == CHECK_HI) || (state_nxt == CHECK_LO);

    // Stage 1: qualifier state and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            q_o        <= 1'b0;
            qb_o       <= 1'b1;
            rise_o     <= 1'b0;
            fall_o     <= 1'b0;
            busy_o     <= 1'b0;
            rise_cnt_o <= 8'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            q_o        <= level_nxt;
            qb_o       <= ~level_nxt;
            rise_o     <= rise_nxt;
            fall_o     <= fall_nxt;
            busy_o     <= busy_nxt;
            rise_cnt_o <= rise_cnt_o + 8'(rise_nxt);
        end
    end

endmodule
